// File: rtl/ram_pkg.sv
// Shared types and elaboration helpers for the ram_sync_dp buffer.
// Optional same-cycle read/write bypass is selected with the RAM_BYPASS_EN macro.
package ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int unsigned be_count(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Words must be whole bytes and the array must fit in the address space.
  function automatic bit cfg_ok(input int unsigned addr_w,
                                input int unsigned data_w,
                                input int unsigned depth);
    return (addr_w >= 1) && (addr_w < 31) &&
           (data_w >= 8) && ((data_w % 8) == 0) &&
           (depth >= 2) && (depth <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/ram_array.sv
// Storage only: one byte-enabled write port and one registered read port, no reset.
module ram_array
  import ram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int NB = be_count(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Read returns the pre-write contents when both ports hit the same word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ram_sync_dp.sv
// Simple-dual-port RAM with clear-after-reset sequencer and handshaked registered reads.
// Define RAM_BYPASS_EN to forward same-cycle write data into a colliding read.
module ram_sync_dp
  import ram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  wr_en,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_dvalid,
  input  logic                  rd_dready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_err
);

  localparam int                NB        = be_count(DATA_W);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  generate
    if (!cfg_ok(ADDR_W, DATA_W, DEPTH)) begin : g_bad_cfg
      $error("ram_sync_dp: illegal ADDR_W/DATA_W/DEPTH combination");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              rd_dvalid_q, rd_dvalid_d;
  logic              rd_err_q, rd_err_d;
  logic              rd_hit_q, rd_hit_d;

  logic              run;
  logic              wr_in_range, rd_in_range;
  logic              wr_fire, rd_accept;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [NB-1:0]     arr_be;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] rd_word;

  assign run         = (state_q == ST_RUN);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign wr_fire     = run & wr_en & wr_in_range;
  assign rd_ready    = run & (~rd_dvalid_q | rd_dready);
  assign rd_accept   = rd_valid & rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clr_q       <= '0;
      rd_dvalid_q <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      rd_dvalid_q <= rd_dvalid_d;
      rd_err_q    <= rd_err_d;
      rd_hit_q    <= rd_hit_d;
    end
  end

  // While clearing, the sequencer owns the write port and user writes are ignored.
  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    arr_we    = 1'b0;
    arr_addr  = wr_addr;
    arr_wdata = wr_data;
    arr_be    = wr_be;
    case (state_q)
      ST_INIT: begin
        arr_we    = 1'b1;
        arr_addr  = clr_q;
        arr_wdata = '0;
        arr_be    = '1;
        if (clr_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      ST_RUN: begin
        arr_we = wr_fire;
      end
      default: begin
        state_d = ST_INIT;
        clr_d   = '0;
      end
    endcase
  end

  // One-entry response register: reload on accept, otherwise hold until taken.
  always_comb begin
    rd_dvalid_d = rd_dvalid_q;
    rd_err_d    = rd_err_q;
    rd_hit_d    = rd_hit_q;
    if (rd_accept) begin
      rd_dvalid_d = 1'b1;
      rd_err_d    = ~rd_in_range;
      rd_hit_d    = rd_in_range;
    end else if (rd_dready) begin
      rd_dvalid_d = 1'b0;
    end
  end

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we      (arr_we),
    .wr_addr (arr_addr),
    .wr_data (arr_wdata),
    .wr_be   (arr_be),
    .rd_en   (rd_accept & rd_in_range),
    .rd_addr (rd_addr),
    .rd_data (arr_rdata)
  );

`ifdef RAM_BYPASS_EN
  logic [NB-1:0]     byp_be_q, byp_be_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_be_q   <= '0;
      byp_data_q <= '0;
    end else begin
      byp_be_q   <= byp_be_d;
      byp_data_q <= byp_data_d;
    end
  end

  // Capture colliding write bytes alongside the read so the held response stays stable.
  always_comb begin
    byp_be_d   = byp_be_q;
    byp_data_d = byp_data_q;
    if (rd_accept) begin
      byp_be_d   = (wr_fire && (wr_addr == rd_addr)) ? wr_be : '0;
      byp_data_d = wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_merge
      assign rd_word[8*gi +: 8] = byp_be_q[gi] ? byp_data_q[8*gi +: 8]
                                               : arr_rdata[8*gi +: 8];
    end
  endgenerate
`else
  assign rd_word = arr_rdata;
`endif

  assign init_done = run;
  assign wr_ready  = run;
  assign rd_dvalid = rd_dvalid_q;
  assign rd_err    = rd_err_q;
  assign rd_data   = rd_hit_q ? rd_word : '0;

endmodule
